// File: rtl/seq_div_nxm_pkg.sv
// rtl/seq_div_nxm_pkg.sv - shared state encodings and default widths for seq_div_nxm
package seq_div_nxm_pkg;

  localparam int DEF_N = 8;  // dividend / quotient width
  localparam int DEF_M = 4;  // divisor / remainder width

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_div_nxm_div_step_m.sv
// rtl/seq_div_nxm_div_step_m.sv - one combinational restoring-division step
// Ports:
//   shifted   in  M+1  partial remainder shifted left with next dividend bit
//   divisor   in  M    unsigned divisor
//   rem_next  out M    partial remainder after this step
//   q_bit     out 1    quotient bit produced by this step
module seq_div_nxm_div_step_m #(
  parameter int M = 4
) (
  input  logic [M:0]   shifted,
  input  logic [M-1:0] divisor,
  output logic [M-1:0] rem_next,
  output logic         q_bit
);

  logic fits;

  // The restored remainder is always below the divisor, so it fits in M bits
  // even though the shifted operand needs M+1.
  assign fits     = (shifted >= {1'b0, divisor});
  assign q_bit    = fits;
  assign rem_next = fits ? M'(shifted - {1'b0, divisor}) : shifted[M-1:0];

endmodule

// File: rtl/seq_div_nxm.sv
// rtl/seq_div_nxm.sv - iterative restoring divider, one quotient bit per clock
// Ports:
//   clk          in   1  rising-edge clock
//   rst_n        in   1  synchronous active-low reset
//   start        in   1  request, sampled only when not busy
//   dividend     in   N  unsigned dividend, captured on accepted start
//   divisor      in   M  unsigned divisor, captured on accepted start
//   busy         out  1  operation in flight
//   done         out  1  one-cycle pulse, results valid
//   quotient     out  N  quotient, held until next done
//   remainder    out  M  remainder, held until next done
//   div_by_zero  out  1  divisor was zero for the reported op
module seq_div_nxm
  import seq_div_nxm_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int M = DEF_M
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [M-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [M-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N);

  state_t        state, state_nxt;
  logic [CW-1:0] count;
  logic          fin;      // all N iterations done; next RUN edge publishes
  logic [N-1:0]  dvd_sr;   // dividend, consumed MSB first
  logic [N-1:0]  q_sr;     // quotient bits, shifted in MSB first
  logic [M-1:0]  dsr;
  logic [M-1:0]  rem;
  logic [M:0]    step_in;
  logic [M-1:0]  step_rem;
  logic          step_q;
  logic          accept;

  assign step_in = {rem, dvd_sr[N-1]};

  seq_div_nxm_div_step_m #(.M(M)) u_step (
    .shifted  (step_in),
    .divisor  (dsr),
    .rem_next (step_rem),
    .q_bit    (step_q)
  );

  assign accept = start && ((state == S_IDLE) || (state == S_DONE));
  assign busy   = (state == S_RUN);
  assign done   = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (fin) state_nxt = S_DONE;
      S_DONE:  state_nxt = start ? S_RUN : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count       <= '0;
      fin         <= 1'b0;
      dvd_sr      <= '0;
      q_sr        <= '0;
      dsr         <= '0;
      rem         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      dvd_sr <= dividend;
      dsr    <= divisor;
      rem    <= '0;
      q_sr   <= '0;
      count  <= CW'(N - 1);
      fin    <= 1'b0;
    end else if (state == S_RUN) begin
      if (fin) begin
        // A zero divisor naturally yields all-ones quotient and the low
        // dividend bits as remainder; only the flag needs explicit logic.
        quotient    <= q_sr;
        remainder   <= rem;
        div_by_zero <= (dsr == '0);
      end else begin
        rem    <= step_rem;
        q_sr   <= {q_sr[N-2:0], step_q};
        dvd_sr <= {dvd_sr[N-2:0], 1'b0};
        if (count == '0) begin
          fin <= 1'b1;
        end else begin
          count <= count - CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_div_nxm.sv
// tb/tb_seq_div_nxm.sv - self-checking bench for seq_div_nxm
module tb_seq_div_nxm;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int n_cmp;
  int n_fail;

  seq_div_nxm #(.N(8), .M(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [3:0] b;
    logic [7:0] q;
    logic [3:0] r;
    logic       dbz;
  } vec_t;

  vec_t vt [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Start one op from IDLE, then count edges until done; returns edges seen.
  task automatic run_op(input logic [7:0] a, input logic [3:0] b, output int edges);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = ~a;
    divisor  = ~b;
    edges = 0;
    do begin
      @(posedge clk);
      edges++;
      #1;
    end while (!done && edges < 40);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int         edges;
    int         dones;
    logic [7:0] eq;
    logic [3:0] er;
    logic       ed;
    logic [7:0] pa;
    logic [3:0] pb;
    logic [7:0] cap_q;
    logic [3:0] cap_r;
    logic [12:0] nx;

    n_cmp  = 0;
    n_fail = 0;

    vt[0] = '{8'd200, 4'd7,  8'd28,  4'd4,  1'b0};
    vt[1] = '{8'd255, 4'd1,  8'd255, 4'd0,  1'b0};
    vt[2] = '{8'd5,   4'd15, 8'd0,   4'd5,  1'b0};
    vt[3] = '{8'd0,   4'd9,  8'd0,   4'd0,  1'b0};
    vt[4] = '{8'd100, 4'd0,  8'hFF,  4'h4,  1'b1};
    vt[5] = '{8'd100, 4'd10, 8'd10,  4'd0,  1'b0};
    vt[6] = '{8'd255, 4'd15, 8'd17,  4'd0,  1'b0};
    vt[7] = '{8'd13,  4'd4,  8'd3,   4'd1,  1'b0};
    vt[8] = '{8'd195, 4'd13, 8'd15,  4'd0,  1'b0};
    vt[9] = '{8'd1,   4'd1,  8'd1,   4'd0,  1'b0};

    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_q", quotient, 0);
    check("reset_r", remainder, 0);
    check("reset_dbz", div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op(vt[i].a, vt[i].b, edges);
      check($sformatf("vec%0d_latency", i), edges, 9);
      check($sformatf("vec%0d_q", i), quotient, vt[i].q);
      check($sformatf("vec%0d_r", i), remainder, vt[i].r);
      check($sformatf("vec%0d_dbz", i), div_by_zero, vt[i].dbz);
      check($sformatf("vec%0d_busy_at_done", i), busy, 0);
    end

    repeat (4) @(posedge clk);
    #1;
    check("held_done_low", done, 0);
    check("held_q", quotient, 8'd1);
    check("held_r", remainder, 4'd0);

    // Exhaustive back-to-back with start held high.
    @(negedge clk);
    dividend = 8'd0;
    divisor  = 4'd0;
    start    = 1'b1;
    @(posedge clk);
    #1;
    pa = 8'd0;
    pb = 4'd0;
    dividend = 8'd0;
    divisor  = 4'd1;
    for (int idx = 1; idx <= 4096; idx++) begin
      edges = 0;
      do begin
        @(posedge clk);
        edges++;
        #1;
      end while (!done && edges < 40);
      if (pb == 4'd0) begin
        eq = 8'hFF;
        er = pa[3:0];
        ed = 1'b1;
      end else begin
        eq = pa / {4'd0, pb};
        er = 4'(pa % {4'd0, pb});
        ed = 1'b0;
      end
      check($sformatf("exh_%0d_%0d_latency", pa, pb), edges, 9);
      check($sformatf("exh_%0d_%0d_result", pa, pb),
            {quotient, remainder, div_by_zero}, {eq, er, ed});
      if (idx == 4096) start = 1'b0;
      @(posedge clk);
      #1;
      if (idx < 4096) begin
        check($sformatf("exh_%0d_accepted", idx), busy, 1);
        pa = dividend;
        pb = divisor;
        nx = 13'(idx + 1);
        dividend = nx[11:4];
        divisor  = nx[3:0];
      end
    end
    check("exh_end_idle", busy, 0);

    // start pulsed mid-RUN must be ignored.
    @(negedge clk);
    dividend = 8'd200;
    divisor  = 4'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    dones = 0;
    edges = 0;
    cap_q = '0;
    cap_r = '0;
    for (int e = 1; e <= 30; e++) begin
      if (e == 4) begin
        dividend = 8'd99;
        divisor  = 4'd5;
        start    = 1'b1;
      end
      if (e == 5) start = 1'b0;
      @(posedge clk);
      #1;
      if (done) begin
        dones++;
        edges = e;
        cap_q = quotient;
        cap_r = remainder;
      end
    end
    check("midrun_done_count", dones, 1);
    check("midrun_latency", edges, 9);
    check("midrun_q", cap_q, 8'd28);
    check("midrun_r", cap_r, 4'd4);

    // Reset at iteration 4 abandons the op.
    @(negedge clk);
    dividend = 8'd200;
    divisor  = 4'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_q", quotient, 0);
    check("rst_mid_r", remainder, 0);
    check("rst_mid_dbz", div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int e = 0; e < 15; e++) begin
      @(posedge clk);
      #1;
      if (done || busy) dones++;
    end
    check("rst_mid_no_done", dones, 0);

    run_op(8'd60, 4'd7, edges);
    check("after_rst_latency", edges, 9);
    check("after_rst_q", quotient, 8'd8);
    check("after_rst_r", remainder, 4'd4);
    check("after_rst_dbz", div_by_zero, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
